// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants for the PS/2 key decoder: scan codes (set 2), ASCII codes,
// frame FSM state encoding and the scan-code-to-ASCII mapping.
package ps2_key_decoder_pkg;

  // Prefix and release codes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // Letter make codes
  localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  // ASCII values presented on key
  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_ENTER = 8'h0A;
  localparam logic [7:0] KEY_BKSP  = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // KEY_NONE doubles as the "unmapped" marker since no mapped key is 8'h00.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] ascii;
    case (code)
      SC_A: ascii = 8'h41;  SC_B: ascii = 8'h42;  SC_C: ascii = 8'h43;
      SC_D: ascii = 8'h44;  SC_E: ascii = 8'h45;  SC_F: ascii = 8'h46;
      SC_G: ascii = 8'h47;  SC_H: ascii = 8'h48;  SC_I: ascii = 8'h49;
      SC_J: ascii = 8'h4A;  SC_K: ascii = 8'h4B;  SC_L: ascii = 8'h4C;
      SC_M: ascii = 8'h4D;  SC_N: ascii = 8'h4E;  SC_O: ascii = 8'h4F;
      SC_P: ascii = 8'h50;  SC_Q: ascii = 8'h51;  SC_R: ascii = 8'h52;
      SC_S: ascii = 8'h53;  SC_T: ascii = 8'h54;  SC_U: ascii = 8'h55;
      SC_V: ascii = 8'h56;  SC_W: ascii = 8'h57;  SC_X: ascii = 8'h58;
      SC_Y: ascii = 8'h59;  SC_Z: ascii = 8'h5A;
      SC_ENTER: ascii = KEY_ENTER;
      SC_BKSP:  ascii = KEY_BKSP;
      default:  ascii = KEY_NONE;
    endcase
    return ascii;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key interface between the PS/2 decoder (master) and the game control FSM (slave).
interface ps2_key_decoder_if;
  logic [7:0] key;
  logic       key_valid;
  logic       parity_err;

  modport master (output key, key_valid, parity_err);
  modport slave  (input  key, key_valid, parity_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw pins, detects falling edges of the
// PS/2 clock and assembles 11-bit frames into bytes with odd parity checking.
module ps2_frame_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       parity_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] dat_sync_reg;
  logic                   clk_prev_reg;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall_edge;

  frame_state_t  state_reg;
  logic [2:0]    bitcnt_reg;
  logic [7:0]    shift_reg;
  logic          par_reg;
  logic [CW-1:0] tmo_reg;

  assign clk_s     = clk_sync_reg[SYNC_STAGES-1];
  assign dat_s     = dat_sync_reg[SYNC_STAGES-1];
  assign fall_edge = clk_prev_reg & ~clk_s;

  // Synchroniser chains for both pins (idle-high) plus the previous synced clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_reg <= '1;
      dat_sync_reg <= '1;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], ps2_dat};
      clk_prev_reg <= clk_s;
    end
  end

  // Frame FSM with mid-frame timeout; strobe and error outputs are one-cycle pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      bitcnt_reg  <= 3'd0;
      shift_reg   <= 8'h00;
      par_reg     <= 1'b0;
      tmo_reg     <= '0;
      rx_byte     <= 8'h00;
      byte_strobe <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      parity_err  <= 1'b0;
      if (state_reg == ST_IDLE) begin
        tmo_reg <= '0;
        if (fall_edge && !dat_s) begin
          state_reg  <= ST_DATA;
          bitcnt_reg <= 3'd0;
        end
      end else if (fall_edge) begin
        tmo_reg <= '0;
        case (state_reg)
          ST_DATA: begin
            // LSB arrives first, so shift in from the top.
            shift_reg  <= {dat_s, shift_reg[7:1]};
            bitcnt_reg <= bitcnt_reg + 3'd1;
            if (bitcnt_reg == 3'd7) state_reg <= ST_PARITY;
          end
          ST_PARITY: begin
            par_reg   <= dat_s;
            state_reg <= ST_STOP;
          end
          ST_STOP: begin
            if ((^{shift_reg, par_reg}) && dat_s) begin
              rx_byte     <= shift_reg;
              byte_strobe <= 1'b1;
            end else begin
              parity_err  <= 1'b1;
            end
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end else if (tmo_reg == TMO_LAST) begin
        // Abandoned frame: drop it quietly.
        state_reg <= ST_IDLE;
        tmo_reg   <= '0;
      end else begin
        tmo_reg <= tmo_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: turns scan code set 2 make/break sequences into the
// ASCII of the currently held key, with a pulse on every accepted make code.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  ps2_key_decoder_if.master  key_bus
);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_perr;
  logic [7:0] mapped;

  logic [7:0] key_reg;
  logic       valid_reg;
  logic       ext_pending_reg;
  logic       break_pending_reg;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_frame_rx (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .rx_byte     (rx_byte),
    .byte_strobe (rx_strobe),
    .parity_err  (rx_perr)
  );

  assign mapped = scan_to_ascii(rx_byte);

  // Make/break decode: last pressed key wins, release only clears a matching key.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_reg           <= KEY_NONE;
      valid_reg         <= 1'b0;
      ext_pending_reg   <= 1'b0;
      break_pending_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (rx_perr) begin
        // A corrupted byte may have been a prefix; forget any pending state.
        ext_pending_reg   <= 1'b0;
        break_pending_reg <= 1'b0;
      end else if (rx_strobe) begin
        if (rx_byte == SC_EXT) begin
          ext_pending_reg <= 1'b1;
        end else if (rx_byte == SC_BREAK) begin
          break_pending_reg <= 1'b1;
        end else if (ext_pending_reg) begin
          // Extended keys are not mapped; swallow the byte.
          ext_pending_reg   <= 1'b0;
          break_pending_reg <= 1'b0;
        end else if (break_pending_reg) begin
          if (mapped == key_reg && key_reg != KEY_NONE) key_reg <= KEY_NONE;
          break_pending_reg <= 1'b0;
        end else if (mapped != KEY_NONE) begin
          key_reg   <= mapped;
          valid_reg <= 1'b1;
        end
      end
    end
  end

  assign key_bus.key        = key_reg;
  assign key_bus.key_valid  = valid_reg;
  assign key_bus.parity_err = rx_perr;

endmodule
